// File: rtl/lrn_pkg.sv
// Shared constants and types for the LRN window-buffer stage and its mapper_lrn companion.
package lrn_pkg;

    localparam int LRN_M_WIDTH    = 4;
    localparam int LRN_V_WIDTH    = 2;
    localparam int LRN_DATA_WIDTH = 16;

    // Sum of up to 2**mw squares of dw-bit values can never overflow this width.
    function automatic int sum_width(input int dw, input int mw);
        return 2 * dw + mw;
    endfunction

    localparam int LRN_SUM_WIDTH = sum_width(LRN_DATA_WIDTH, LRN_M_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SQ       = 3'd2,
        ST_EMIT     = 3'd3,
        ST_WAIT_DIV = 3'd4
    } state_t;

endpackage

// File: rtl/lrn_window_buffer_if.sv
// Operand/result link between the window buffer (master) and the LRN divider (slave).
interface lrn_window_buffer_if
    import lrn_pkg::*;
#(
    parameter int M_WIDTH    = LRN_M_WIDTH,
    parameter int DATA_WIDTH = LRN_DATA_WIDTH,
    parameter int SUM_WIDTH  = sum_width(DATA_WIDTH, M_WIDTH)
) ();

    logic                         sq_valid;
    logic                         sq_ready;
    logic signed [DATA_WIDTH-1:0] sq_x;
    logic        [SUM_WIDTH-1:0]  sq_sum;
    logic        [M_WIDTH-1:0]    sq_ch;
    logic                         div_out_valid;

    modport master (
        output sq_valid, sq_x, sq_sum, sq_ch,
        input  sq_ready, div_out_valid
    );

    modport slave (
        input  sq_valid, sq_x, sq_sum, sq_ch,
        output sq_ready, div_out_valid
    );

endinterface

// File: rtl/lrn_window_sum.sv
// Square register file plus the sliding cross-channel sum of squares.
module lrn_window_sum
    import lrn_pkg::*;
#(
    parameter int M_WIDTH    = LRN_M_WIDTH,
    parameter int V_WIDTH    = LRN_V_WIDTH,
    parameter int DATA_WIDTH = LRN_DATA_WIDTH,
    parameter int SUM_WIDTH  = sum_width(DATA_WIDTH, M_WIDTH)
) (
    input  logic                         core_clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         seed_en,
    input  logic        [M_WIDTH-1:0]    seed_idx,
    input  logic signed [DATA_WIDTH-1:0] seed_x,
    input  logic                         advance,
    input  logic        [M_WIDTH-1:0]    ch,
    input  logic        [V_WIDTH-1:0]    pad,
    input  logic        [M_WIDTH-1:0]    dim,
    output logic        [SUM_WIDTH-1:0]  run
);

    localparam int SQ_WIDTH = 2 * DATA_WIDTH;
    localparam int IW       = ((M_WIDTH > V_WIDTH) ? M_WIDTH : V_WIDTH) + 2;

    logic        [SQ_WIDTH-1:0]  sq_mem [2**M_WIDTH];
    logic signed [SQ_WIDTH-1:0]  prod;
    logic        [SQ_WIDTH-1:0]  seed_sq;
    logic        [IW-1:0]        hi_w;
    logic        [M_WIDTH-1:0]   hi_idx, lo_idx;
    logic                        add_ok, sub_ok, seed_in_win;
    logic        [SUM_WIDTH-1:0] add_term, sub_term, seed_term;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        prod        = SQ_WIDTH'(seed_x) * SQ_WIDTH'(seed_x);
        seed_sq     = $unsigned(prod);
        seed_in_win = IW'(seed_idx) <= IW'(pad);
        hi_w        = IW'(ch) + IW'(pad) + IW'(1);
        add_ok      = hi_w < IW'(dim);
        sub_ok      = IW'(ch) >= IW'(pad);
        // Indices may wrap when out of window; they are only used when the *_ok flag is set.
        hi_idx      = ch + M_WIDTH'(pad) + M_WIDTH'(1);
        lo_idx      = ch - M_WIDTH'(pad);
        add_term    = add_ok      ? SUM_WIDTH'(sq_mem[hi_idx]) : '0;
        sub_term    = sub_ok      ? SUM_WIDTH'(sq_mem[lo_idx]) : '0;
        seed_term   = seed_in_win ? SUM_WIDTH'(seed_sq)        : '0;
    end

    // NOTE: the square file is plain storage, always written before it is read, so it carries no reset.
    always_ff @(posedge core_clk) begin
        if (seed_en) sq_mem[seed_idx] <= seed_sq;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge core_clk or negedge reset) begin
        if (!reset)       run <= '0;
        else if (clear)   run <= '0;
        else if (seed_en) run <= run + seed_term;
        else if (advance) run <= run + add_term - sub_term;
    end

endmodule

// File: rtl/lrn_window_buffer.sv
// LRN window buffer: captures one spatial position's channels, then streams (x, window sum) to the divider.
module lrn_window_buffer
    import lrn_pkg::*;
#(
    parameter int M_WIDTH    = LRN_M_WIDTH,
    parameter int V_WIDTH    = LRN_V_WIDTH,
    parameter int DATA_WIDTH = LRN_DATA_WIDTH,
    parameter int SUM_WIDTH  = sum_width(DATA_WIDTH, M_WIDTH)
) (
    input  logic                         core_clk,
    input  logic                         reset,
    input  logic        [M_WIDTH-1:0]    dim3,
    input  logic        [V_WIDTH-1:0]    padding_num,
    input  logic                         r_enable,
    input  logic signed [DATA_WIDTH-1:0] r_data,
    output logic                         full_flag,
    lrn_window_buffer_if.master          dvd,
    output logic                         normalized_window_rr,
    output logic                         busy,
    output logic                         err_overrun
);

    state_t                       state;
    logic                         rd_v, cap, hs, start;
    logic        [M_WIDTH-1:0]    dim_q, wr_cnt, sq_idx, ch, div_cnt;
    logic        [V_WIDTH-1:0]    pad_q;
    logic signed [DATA_WIDTH-1:0] win_buf [2**M_WIDTH];
    logic        [SUM_WIDTH-1:0]  run;

    always_comb begin
        cap        = rd_v;
        start      = (state == ST_IDLE) && cap && (dim3 != '0);
        hs         = (state == ST_EMIT) && dvd.sq_ready;
        busy       = (state != ST_IDLE);
        dvd.sq_valid = (state == ST_EMIT);
        dvd.sq_x   = dvd.sq_valid ? win_buf[ch] : '0;
        dvd.sq_sum = dvd.sq_valid ? run : '0;
        dvd.sq_ch  = dvd.sq_valid ? ch : '0;
    end

    always_ff @(posedge core_clk) begin
        if (start)                            win_buf[0]      <= r_data;
        else if (cap && (state == ST_LOAD))   win_buf[wr_cnt] <= r_data;
    end

    always_ff @(posedge core_clk or negedge reset) begin
        if (!reset) begin
            state                <= ST_IDLE;
            rd_v                 <= 1'b0;
            dim_q                <= '0;
            pad_q                <= '0;
            wr_cnt               <= '0;
            sq_idx               <= '0;
            ch                   <= '0;
            div_cnt              <= '0;
            full_flag            <= 1'b0;
            normalized_window_rr <= 1'b0;
            err_overrun          <= 1'b0;
        end else begin
            rd_v                 <= r_enable;
            full_flag            <= 1'b0;
            normalized_window_rr <= 1'b0;
            if (cap && (state inside {ST_SQ, ST_EMIT, ST_WAIT_DIV}))
                err_overrun <= 1'b1;
            if ((state inside {ST_EMIT, ST_WAIT_DIV}) && dvd.div_out_valid && (div_cnt != dim_q))
                div_cnt <= div_cnt + M_WIDTH'(1);

            case (state)
                ST_IDLE: if (start) begin
                    dim_q   <= dim3;
                    pad_q   <= padding_num;
                    wr_cnt  <= M_WIDTH'(1);
                    sq_idx  <= '0;
                    ch      <= '0;
                    div_cnt <= '0;
                    if (dim3 == M_WIDTH'(1)) begin
                        full_flag <= 1'b1;
                        state     <= ST_SQ;
                    end else begin
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: if (cap) begin
                    wr_cnt <= wr_cnt + M_WIDTH'(1);
                    if (wr_cnt + M_WIDTH'(1) == dim_q) begin
                        full_flag <= 1'b1;
                        state     <= ST_SQ;
                    end
                end
                ST_SQ: begin
                    sq_idx <= sq_idx + M_WIDTH'(1);
                    if (sq_idx == dim_q - M_WIDTH'(1)) state <= ST_EMIT;
                end
                ST_EMIT: if (hs) begin
                    ch <= ch + M_WIDTH'(1);
                    if (ch == dim_q - M_WIDTH'(1)) state <= ST_WAIT_DIV;
                end
                ST_WAIT_DIV: if (div_cnt == dim_q) begin
                    normalized_window_rr <= 1'b1;
                    state                <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    lrn_window_sum #(
        .M_WIDTH   (M_WIDTH),
        .V_WIDTH   (V_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .SUM_WIDTH (SUM_WIDTH)
    ) u_sum (
        .core_clk(core_clk),
        .reset   (reset),
        .clear   ((state == ST_IDLE) || (state == ST_LOAD)),
        .seed_en (state == ST_SQ),
        .seed_idx(sq_idx),
        .seed_x  (win_buf[sq_idx]),
        .advance (hs),
        .ch      (ch),
        .pad     (pad_q),
        .dim     (dim_q),
        .run     (run)
    );

endmodule
